// File: rtl/mux4_rr_arbiter_if.sv
// Bundle carrying the arbiter's request/select/handshake signals.
// The arbiter uses the master view; the requesting and consuming side uses slave.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic       out_ready;
  logic       s0;
  logic       s1;
  logic [3:0] gnt;
  logic       out_valid;
  logic       busy;

  modport master (
    input  req, out_ready,
    output s0, s1, gnt, out_valid, busy
  );

  modport slave (
    output req, out_ready,
    input  s0, s1, gnt, out_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pins of a 4:1 mux, with a bounded
// number of accepted beats per grant and a valid/ready output handshake.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  mux4_rr_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       busy;
  logic       out_valid;
  logic       xfer;
  logic       last_beat;
  logic       release_c;
  logic [1:0] base;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       win_found;

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & bus.req[sel_q];
  assign xfer      = out_valid & bus.out_ready;
  assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_c = busy & (~bus.req[sel_q] | (xfer & last_beat));

  // On release the search starts after the current holder, so it comes last.
  assign base = busy ? sel_q : last_q;

  always_comb begin
    win_found = 1'b0;
    winner    = base;
    cand      = base;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (win_found) begin
        state_d = GRANT;
        gnt_d   = 4'b0001 << winner;
        sel_d   = winner;
        cnt_d   = '0;
      end
    end else begin
      if (release_c) begin
        last_d = sel_q;
        cnt_d  = '0;
        if (win_found) begin
          gnt_d = 4'b0001 << winner;
          sel_d = winner;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end else if (xfer) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.s0        = sel_q[1];
  assign bus.s1        = sel_q[0];
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Sequential controller for the 4-to-1 mux (mux_4to1) datapath.
- Shares the single mux output among four requesters, using round-robin arbitration with a bounded burst per grant.
- Drives the mux select lines s0/s1 directly and provides a valid/ready handshake toward the downstream consumer of the mux output.
- Sits between the requesting sources (mux inputs i0..i3) and the mux select pins.

Parameters:
MAX_BURST, 4, max accepted beats per grant before forced rotation; legal 1..255, 0 illegal.
CNT_W, 8, beat counter width; must satisfy 2^CNT_W > MAX_BURST.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  request vector; req[k] belongs to mux input ik.
out_ready  input  1  downstream accepts the current beat.
s0  output  1  mux select MSB; {s0,s1} = granted index.
s1  output  1  mux select LSB.
gnt  output  4  one-hot grant, registered.
out_valid  output  1  beat on mux output is valid.
busy  output  1  high while in GRANT.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values (effective immediately on rst assertion, including mid-burst):
  - state=IDLE, gnt=0000, s0=0, s1=0, out_valid=0, busy=0, beat count=0.
  - Round-robin pointer last=3, so index 0 has first priority after reset.
- Two-state FSM: IDLE, GRANT. gnt, s0, s1, busy and the counter are registered.
- out_valid = busy & req[idx], combinational, where idx={s0,s1}.
- Arbitration:
  - Search order is last+1, last+2, last+3, last, all mod 4 (wrap-around).
  - The first asserted req wins.
- IDLE:
  - If req != 0, arbitrate. On the next edge: state=GRANT, gnt=onehot(winner), {s0,s1}=winner, count=0.
  - Latency from req to gnt is 1 cycle.
  - If req == 0, stay in IDLE; s0/s1 keep their previous value.
- GRANT:
  - A transfer occurs on a cycle where out_valid & out_ready; on that edge, count increments.
  - Release condition (evaluated each cycle): req[idx]==0, OR (transfer AND count==MAX_BURST-1).
  - On release, last=idx and arbitration runs in the same cycle over the current req, with the released requester re-included at lowest priority.
    - If a winner exists, next edge loads the new gnt, {s0,s1} and count=0, staying in GRANT with no bubble.
    - If no winner exists, go to IDLE with gnt=0000 and busy=0.
  - out_ready low with req held: grant held indefinitely; count frozen; no timeout.
  - A requester dropping req mid-burst loses the grant immediately; out_valid=0 that cycle and no transfer is counted.
  - A sole persistent requester is re-granted after each burst: gnt toggles through a new grant load with count reset, and beats continue with no gap cycle.
- MAX_BURST=1: rotation after every accepted beat.
- s0/s1 change only on grant load, so the mux select is stable for the whole grant.
- Invariant: gnt is one-hot or zero at all times.
- Invariant: out_valid never asserts in IDLE.

Test Plan:
- Reset, then req=0001, out_ready=1:
  - gnt=0001 one cycle after req; {s0,s1}=00; out_valid=1.
  - 4 beats accepted, then re-grant to 0 with count=0.
- req=1111 held, out_ready=1, MAX_BURST=4:
  - Grants proceed 0,1,2,3,0, each for exactly 4 beats.
  - {s0,s1} steps 00,01,10,11,00 with no idle cycle between grants.
- Granted index 2 with out_ready=0 for 10 cycles:
  - gnt=0100 held; count stays 0; out_valid=1.
  - Raising out_ready resumes counting.
- Grant on index 1; drop req[1] after 2 beats while req[3]=1:
  - out_valid=0 that cycle.
  - Next edge gnt=1000 and {s0,s1}=11.
- Assert rst mid-burst (count=2, gnt=0010):
  - Outputs clear immediately, without waiting for a clock edge.
  - After release with req=0011, first grant is index 0 (pointer back to 3).
- MAX_BURST=1, req=0101:
  - Grants alternate 0,2,0,2 every accepted beat; gnt is always one-hot.
